fa_bist_ctrl: RTL
=================

# fa_bist_ctrl

Built-in self-test controller for a single-bit full adder. On a start pulse it steps the adder's inputs {ci, a, b} through all eight combinations, 000 to 111. It samples s and co after a programmable settle time, compares them against the full-adder truth table, and reports a per-vector fail map, an error count and pass/done status. It sits beside any full-adder instance (dataflow, behavioral or case-based) as the hardware driver and checker for that adder.

## Interface
Parameters:
- SETTLE, 2: wait cycles between driving a vector and sampling the response. Legal range 1..15.
- ERR_W, 3: width of the error counter, which saturates.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  starts a run; sampled only in IDLE
- ci_o  out  1  carry-in driven to the adder under test
- a_o  out  1  operand a driven to the adder
- b_o  out  1  operand b driven to the adder
- s_i  in  1  sum returned by the adder
- co_i  in  1  carry-out returned by the adder
- busy  out  1  high while a run is in progress
- done  out  1  high once a run completes; holds until the next accepted start
- pass  out  1  high with done when no vector failed
- err_cnt  out  ERR_W  number of failing vectors, saturating at 2^ERR_W-1
- fail_vec  out  8  bit k set when vector k = {ci,a,b} failed

## Operation
- States: IDLE, WAIT, CHECK.
- Reset (asynchronous, at any time, including mid-run):
  - state returns to IDLE;
  - {ci_o,a_o,b_o}=000;
  - busy=0, done=0, pass=0, err_cnt=0, fail_vec=0;
  - internal vector index vec=0 and settle counter cnt=0.
- IDLE, start=1 at a clock edge:
  - vec<=0 and {ci_o,a_o,b_o}<=000;
  - err_cnt<=0, fail_vec<=0, done<=0, pass<=0;
  - busy<=1, cnt<=0, go to WAIT.
- IDLE, start=0: hold all outputs.
- WAIT: cnt increments each cycle. At the edge where cnt==SETTLE-1, go to CHECK.
- CHECK lasts one cycle. At its closing edge:
  - Compare s_i against ci^a^b and co_i against the majority of (ci,a,b), using the values currently driven.
  - On any mismatch, set fail_vec[vec] and increment err_cnt unless it is already at 2^ERR_W-1.
  - If vec<7: vec<=vec+1, drive the new vector, cnt<=0, go to WAIT.
  - If vec==7: go to IDLE with busy<=0, done<=1, and {ci_o,a_o,b_o}<=000.
  - pass<=1 only if no vector failed, including this final one.
- The drive order is fixed: {ci,a,b} = 000, 001, 010, 011, 100, 101, 110, 111.
- start while busy is ignored: it does not restart or extend the run.
- An X or Z on s_i or co_i during CHECK counts as a mismatch in simulation.
- err_cnt counts failing vectors, not failing bits: a vector where both s and co are wrong adds 1.

## Timing
- Each vector is driven for SETTLE+1 cycles: SETTLE cycles in WAIT plus 1 in CHECK. Sampling happens at the last edge of that window.
- Let E0 be the edge that accepts start.
  - busy rises at E0.
  - Vector k is driven from edge E0+k*(SETTLE+1).
  - done, pass and busy=0 appear at E0+8*(SETTLE+1). With the default SETTLE this is 24 cycles.
- fail_vec and err_cnt update at each CHECK edge and are readable while a run is in progress.
- Valid results on done/pass/err_cnt/fail_vec hold until the next accepted start. That start clears them on its own edge.
- A start on the same edge that asserts done is not seen, because the state is still CHECK. The earliest restart is the following cycle.

## Test plan
- Correct adder, SETTLE=2, start pulse -> vectors 000..111 each held 3 cycles; done=1, pass=1, err_cnt=0, fail_vec=8'h00 at E0+24.
- co stuck at 0 -> fail_vec=8'b1110_1000 (vectors 3, 5, 6, 7), err_cnt=4, pass=0, done=1.
- s inverted, ERR_W=3 -> fail_vec=8'hFF, err_cnt saturates at 7, pass=0.
- start held high for the whole run and pulsed again mid-run -> a single run completes at E0+24 with no restart. A new run begins one cycle after done, and its first edge clears done, pass, err_cnt and fail_vec.
- rst_n low during vector 4's WAIT -> all outputs go to reset values immediately; done stays 0 after release until a new start.
- SETTLE=1 with an adder whose co lags by 2 cycles -> co mismatches are recorded (non-zero fail_vec). The same adder with SETTLE=3 -> pass=1.

Source files
------------

// File: rtl/fa_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fa_bist_ctrl
//  Description : Built-in self-test controller for a single-bit full adder.
//                On start it steps {ci,a,b} through 000..111. It waits a
//                programmable settle time before sampling s/co against the
//                full-adder truth table. It records a per-vector fail map and
//                a saturating error count, then reports pass/done.
//  Revision    : 1.0 - initial release
// ============================================================================
module fa_bist_ctrl #(
    parameter int SETTLE = 2,   // wait cycles before sampling, legal 1..15
    parameter int ERR_W  = 3    // saturating error counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ci_o,
    output logic             a_o,
    output logic             b_o,
    input  logic             s_i,
    input  logic             co_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [3:0]       C_CNT_LAST = 4'(SETTLE - 1);
    localparam logic [ERR_W-1:0] C_ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [2:0]       C_VEC_LAST = 3'd7;

    state_t           r_state;
    logic [2:0]       r_vec;
    logic [3:0]       r_cnt;
    logic [2:0]       r_drv;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [7:0]       r_fail;

    state_t           w_state_nxt;
    logic [2:0]       w_vec_nxt;
    logic [3:0]       w_cnt_nxt;
    logic [2:0]       w_drv_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic [ERR_W-1:0] w_err_nxt;
    logic [7:0]       w_fail_nxt;

    logic             w_exp_s;
    logic             w_exp_co;
    logic             w_vec_ok;
    logic [7:0]       w_fail_upd;
    logic [ERR_W-1:0] w_err_upd;

    // Expected adder response for the vector currently driven
    assign w_exp_s  = r_drv[2] ^ r_drv[1] ^ r_drv[0];
    assign w_exp_co = (r_drv[2] & r_drv[1]) | (r_drv[2] & r_drv[0]) | (r_drv[1] & r_drv[0]);

    // Response check; an unknown compare result falls to the else branch so X/Z counts as a failure
    always_comb begin
        w_vec_ok = 1'b0;
        if ((s_i == w_exp_s) && (co_i == w_exp_co)) begin
            w_vec_ok = 1'b1;
        end else begin
            w_vec_ok = 1'b0;
        end
    end

    // Result bookkeeping if this vector is being closed out now
    always_comb begin
        w_fail_upd = r_fail;
        w_err_upd  = r_err;
        if (!w_vec_ok) begin
            w_fail_upd = r_fail | (8'h01 << r_vec);
            if (r_err != C_ERR_MAX) begin
                w_err_upd = r_err + 1'b1;
            end
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_drv_nxt   = r_drv;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_vec_nxt   = 3'd0;
                    w_drv_nxt   = 3'd0;
                    w_err_nxt   = '0;
                    w_fail_nxt  = 8'h00;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = ST_CHECK;
                end
            end

            ST_CHECK: begin
                w_fail_nxt = w_fail_upd;
                w_err_nxt  = w_err_upd;
                if (r_vec != C_VEC_LAST) begin
                    w_vec_nxt   = r_vec + 3'd1;
                    w_drv_nxt   = r_vec + 3'd1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_drv_nxt   = 3'd0;
                    w_pass_nxt  = (w_fail_upd == 8'h00);
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= 3'd0;
            r_cnt   <= 4'd0;
            r_drv   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drv   <= w_drv_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    assign {ci_o, a_o, b_o} = r_drv;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_cnt          = r_err;
    assign fail_vec         = r_fail;

endmodule
`default_nettype wire
